// File: rtl/rv32_hazard_ctrl.sv
// Pipeline hazard controller for a 5-stage RV32 core: resolves memory waits, taken
// branches and load-use hazards into per-stage stall/flush controls, and counts stalled cycles.
module rv32_hazard_ctrl #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4:0]             decode_rs1_in,
    input  logic [4:0]             decode_rs2_in,
    input  logic                   decode_rs1_read_in,
    input  logic                   decode_rs2_read_in,
    input  logic [4:0]             execute_rd_in,
    input  logic                   execute_mem_read_en_in,
    input  logic                   branch_taken_in,
    input  logic                   dmem_req_in,
    input  logic                   dmem_ready_in,
    output logic                   fetch_stall_out,
    output logic                   decode_stall_out,
    output logic                   execute_stall_out,
    output logic                   mem_stall_out,
    output logic                   decode_flush_out,
    output logic                   execute_flush_out,
    output logic [COUNT_WIDTH-1:0] stall_count_out
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_e;

    state_e                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] stall_count_q, stall_count_d;
    logic                   mem_wait;
    logic                   rs1_hit, rs2_hit, load_use;

    assign mem_wait = dmem_req_in && !dmem_ready_in;
    assign rs1_hit  = decode_rs1_read_in && (decode_rs1_in == execute_rd_in);
    assign rs2_hit  = decode_rs2_read_in && (decode_rs2_in == execute_rd_in);
    assign load_use = execute_mem_read_en_in && (execute_rd_in != 5'd0) && (rs1_hit || rs2_hit);

    always_comb begin
        fetch_stall_out   = 1'b0;
        decode_stall_out  = 1'b0;
        execute_stall_out = 1'b0;
        mem_stall_out     = 1'b0;
        decode_flush_out  = 1'b0;
        execute_flush_out = 1'b0;
        state_d           = RUN;
        if (!rst_n) begin
            // Bubbles flow into decode/execute while held in reset.
            decode_flush_out  = 1'b1;
            execute_flush_out = 1'b1;
        end else if (mem_wait) begin
            fetch_stall_out   = 1'b1;
            decode_stall_out  = 1'b1;
            execute_stall_out = 1'b1;
            mem_stall_out     = 1'b1;
            state_d           = MEM_WAIT;
        end else if (branch_taken_in) begin
            decode_flush_out  = 1'b1;
            execute_flush_out = 1'b1;
            state_d           = FLUSH;
        end else if (load_use) begin
            fetch_stall_out   = 1'b1;
            decode_stall_out  = 1'b1;
            execute_flush_out = 1'b1;
        end else if (state_q == FLUSH) begin
            // Squash the fetch that was already in flight when the branch resolved.
            decode_flush_out  = 1'b1;
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (fetch_stall_out && (stall_count_q != {COUNT_WIDTH{1'b1}}))
            stall_count_d = stall_count_q + COUNT_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count_out = stall_count_q;

endmodule

// File: tb/tb_rv32_hazard_ctrl.sv
// Directed bench for rv32_hazard_ctrl: a vector table walked cycle by cycle plus
// hand-written reset and counter-saturation sequences on a default and a 4-bit-counter instance.
module tb_rv32_hazard_ctrl;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       rd1;
        logic       rd2;
        logic [4:0] exrd;
        logic       ld;
        logic       br;
        logic       req;
        logic       rdy;
        logic [5:0] exp;   // {fetch_stall, decode_stall, execute_stall, mem_stall, decode_flush, execute_flush}
    } vec_t;

    localparam int NV = 29;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1, rs2, exrd;
    logic       rd1, rd2, ld, br, req, rdy;

    logic        fs_w, ds_w, es_w, ms_w, df_w, ef_w;
    logic        fs_s, ds_s, es_s, ms_s, df_s, ef_s;
    logic [15:0] cnt_w;
    logic [3:0]  cnt_s;
    logic [5:0]  outs_w, outs_s;

    int tests = 0;
    int fails = 0;
    int exp_w;
    int exp_s;
    vec_t vecs [NV];

    always #5 clk = ~clk;

    assign outs_w = {fs_w, ds_w, es_w, ms_w, df_w, ef_w};
    assign outs_s = {fs_s, ds_s, es_s, ms_s, df_s, ef_s};

    rv32_hazard_ctrl dut_w (
        .clk(clk), .rst_n(rst_n),
        .decode_rs1_in(rs1), .decode_rs2_in(rs2),
        .decode_rs1_read_in(rd1), .decode_rs2_read_in(rd2),
        .execute_rd_in(exrd), .execute_mem_read_en_in(ld),
        .branch_taken_in(br), .dmem_req_in(req), .dmem_ready_in(rdy),
        .fetch_stall_out(fs_w), .decode_stall_out(ds_w),
        .execute_stall_out(es_w), .mem_stall_out(ms_w),
        .decode_flush_out(df_w), .execute_flush_out(ef_w),
        .stall_count_out(cnt_w)
    );

    rv32_hazard_ctrl #(.COUNT_WIDTH(4)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .decode_rs1_in(rs1), .decode_rs2_in(rs2),
        .decode_rs1_read_in(rd1), .decode_rs2_read_in(rd2),
        .execute_rd_in(exrd), .execute_mem_read_en_in(ld),
        .branch_taken_in(br), .dmem_req_in(req), .dmem_ready_in(rdy),
        .fetch_stall_out(fs_s), .decode_stall_out(ds_s),
        .execute_stall_out(es_s), .mem_stall_out(ms_s),
        .decode_flush_out(df_s), .execute_flush_out(ef_s),
        .stall_count_out(cnt_s)
    );

    function automatic vec_t mk(input logic [4:0] a, input logic [4:0] b, input logic r1,
                                input logic r2, input logic [4:0] d, input logic l,
                                input logic t, input logic q, input logic y, input logic [5:0] e);
        vec_t v;
        v.rs1 = a; v.rs2 = b; v.rd1 = r1; v.rd2 = r2; v.exrd = d;
        v.ld = l; v.br = t; v.req = q; v.rdy = y; v.exp = e;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        rs1 = v.rs1; rs2 = v.rs2; rd1 = v.rd1; rd2 = v.rd2; exrd = v.exrd;
        ld = v.ld; br = v.br; req = v.req; rdy = v.rdy;
    endtask

    task automatic idle();
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000));
    endtask

    // Pulse reset between edges, then land just after the next rising edge in RUN.
    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        // Table: one vector per cycle, state carries from row to row.
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000); // idle
        vecs[1]  = mk(0, 5, 0, 1, 5, 1, 0, 0, 0, 6'b110001); // load-use on rs2
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000); // single cycle only
        vecs[3]  = mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 6'b000000); // rd=x0 never a hazard
        vecs[4]  = mk(7, 0, 0, 0, 7, 1, 0, 0, 0, 6'b000000); // rs1 match but not read
        vecs[5]  = mk(7, 0, 1, 0, 7, 1, 0, 0, 0, 6'b110001); // load-use on rs1
        vecs[6]  = mk(7, 0, 1, 0, 7, 0, 0, 0, 0, 6'b000000); // not a load
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 6'b111100); // mem wait x3
        vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 6'b111100);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 6'b111100);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 6'b000000); // ready: runs same cycle
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 6'b000000); // ready without req
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b000011); // branch N
        vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000010); // N+1
        vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000); // N+2
        vecs[15] = mk(0, 5, 0, 1, 5, 1, 1, 0, 0, 6'b000011); // branch beats load-use
        vecs[16] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b000011); // branch again in FLUSH
        vecs[17] = mk(0, 5, 0, 1, 5, 1, 0, 0, 0, 6'b110001); // load-use beats FLUSH flush
        vecs[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000);
        vecs[19] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 6'b111100); // branch under mem wait
        vecs[20] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 6'b111100);
        vecs[21] = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 6'b000011); // flushes on ready cycle
        vecs[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000010);
        vecs[23] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b000011);
        vecs[24] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 6'b111100); // mem wait beats FLUSH
        vecs[25] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000);
        vecs[26] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 6'b111100);
        vecs[27] = mk(0, 5, 0, 1, 5, 1, 0, 1, 1, 6'b110001); // leave MEM_WAIT into load-use
        vecs[28] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000);

        // Reset state, with events present that must be overridden.
        rst_n = 1'b0;
        idle();
        br = 1'b1; req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset outs", 32'(outs_w), 32'b000011);
        chk("reset outs w4", 32'(outs_s), 32'b000011);
        chk("reset count", 32'(cnt_w), 0);
        chk("reset count w4", 32'(cnt_s), 0);
        idle();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        exp_w = 0;
        exp_s = 0;
        for (int i = 0; i < NV; i++) begin
            apply(vecs[i]);
            #3;
            chk($sformatf("vec%0d outs", i), 32'(outs_w), 32'(vecs[i].exp));
            @(posedge clk); #1;
            if (vecs[i].exp[5]) begin
                exp_w = exp_w + 1;
                exp_s = (exp_s == 15) ? 15 : exp_s + 1;
            end
            chk($sformatf("vec%0d count", i), 32'(cnt_w), 32'(exp_w));
            chk($sformatf("vec%0d count w4", i), 32'(cnt_s), 32'(exp_s));
        end

        // Saturation: 20 stalled cycles.
        do_reset();
        req = 1'b1; rdy = 1'b0;
        #2;
        chk("sat stall outs", 32'(outs_w), 32'b111100);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            chk($sformatf("sat w4 k%0d", k), 32'(cnt_s), (k > 15) ? 15 : k);
            chk($sformatf("sat w16 k%0d", k), 32'(cnt_w), 32'(k));
        end
        idle();

        // Reset in the middle of FLUSH, with a nonzero count.
        do_reset();
        apply(mk(0, 5, 0, 1, 5, 1, 0, 0, 0, 6'b110001));
        @(posedge clk); #1;
        br = 1'b1; ld = 1'b0;
        @(posedge clk); #1;
        idle();
        #1;
        chk("mid-flush in FLUSH", 32'(outs_w), 32'b000010);
        chk("mid-flush count before", 32'(cnt_w), 1);
        rst_n = 1'b0;
        #1;
        chk("mid-flush rst outs", 32'(outs_w), 32'b000011);
        chk("mid-flush rst count", 32'(cnt_w), 0);
        rst_n = 1'b1;
        #1;
        chk("mid-flush release outs", 32'(outs_w), 32'b000000);
        @(posedge clk); #1;
        chk("mid-flush next cycle", 32'(outs_w), 32'b000000);

        // Reset in the middle of MEM_WAIT.
        req = 1'b1; rdy = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid-wait rst outs", 32'(outs_w), 32'b000011);
        req = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mid-wait after release", 32'(outs_w), 32'b000000);
        chk("mid-wait count", 32'(cnt_w), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rv32_hazard_ctrl.md
RV32_HAZARD_CTRL -- requirements
Module: rv32_hazard_ctrl

Interface
REQ-001 SHALL have parameter COUNT_WIDTH, default 16, width of the stall performance counter.
REQ-002 SHALL use one clock and an asynchronous, active-low reset.
REQ-003 SHALL have port clk  in  1  rising-edge clock.
REQ-004 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports decode_rs1_in / decode_rs2_in  in  5 each  source registers of the instruction in decode.
REQ-006 SHALL have ports decode_rs1_read_in / decode_rs2_read_in  in  1 each  decode instruction reads rs1 / rs2.
REQ-007 SHALL have port execute_rd_in  in  5  destination register of the instruction in execute.
REQ-008 SHALL have port execute_mem_read_en_in  in  1  instruction in execute is a load.
REQ-009 SHALL have port branch_taken_in  in  1  taken branch resolved in the memory stage; held stable by that stage while it is stalled.
REQ-010 SHALL have ports dmem_req_in / dmem_ready_in  in  1 each  memory-stage data access request / completion.
REQ-011 SHALL have ports fetch_stall_out, decode_stall_out, execute_stall_out, mem_stall_out  out  1 each  hold the stage register.
REQ-012 SHALL have ports decode_flush_out, execute_flush_out  out  1 each  replace the stage output with a bubble.
REQ-013 SHALL have port stall_count_out  out  COUNT_WIDTH  saturating count of stalled cycles.

Function
REQ-014 SHALL implement FSM states RUN, MEM_WAIT, FLUSH; registered state, combinational stall/flush outputs.
REQ-015 SHALL define mem_wait = dmem_req_in && !dmem_ready_in.
REQ-016 SHALL define load_use = execute_mem_read_en_in && execute_rd_in != 0 && ((decode_rs1_read_in && decode_rs1_in == execute_rd_in) || (decode_rs2_read_in && decode_rs2_in == execute_rd_in)).
REQ-017 SHALL apply priority mem_wait > branch_taken_in > load_use > FLUSH-state flush in every state.
REQ-018 SHALL, when mem_wait, assert all four stall outputs, deassert both flushes, and enter/remain in MEM_WAIT.
REQ-019 SHALL, in MEM_WAIT with !mem_wait, proceed as RUN in that same cycle (no dead cycle).
REQ-020 SHALL, when branch_taken_in && !mem_wait, assert decode_flush_out and execute_flush_out, no stalls, and enter FLUSH for exactly one cycle.
REQ-021 SHALL, in FLUSH with no higher-priority event, assert decode_flush_out only (in-flight fetch squash), then return to RUN.
REQ-022 SHALL, in FLUSH with branch_taken_in again, repeat the REQ-020 response and remain in FLUSH one further cycle.
REQ-023 SHALL, on load_use in RUN or FLUSH with no higher-priority event, assert fetch_stall_out, decode_stall_out, execute_flush_out for one cycle; execute_stall_out and mem_stall_out low.
REQ-024 SHALL ignore load_use in the cycle branch_taken_in is honoured.
REQ-025 SHALL treat execute_rd_in == 0 as no hazard.
REQ-026 SHALL increment stall_count_out on each rising edge where fetch_stall_out was high, saturating at all-ones without wrap.
REQ-027 SHALL keep the same mem_wait response when dmem_ready_in rises while dmem_req_in is low (no effect).

Reset
REQ-028 SHALL, while rst_n low, force state RUN, stall_count_out 0, all stall outputs 0, decode_flush_out and execute_flush_out 1.
REQ-029 SHALL, on rst_n assertion mid-MEM_WAIT or mid-FLUSH, abandon the sequence immediately; first cycle after release is RUN.

Verification
REQ-030 Load-use: execute load rd=5, decode rs2=5 read -> one cycle fetch/decode stall + execute_flush, count 0->1.
REQ-031 Mem wait: dmem_req=1, ready=0 for 3 cycles then 1 -> all stalls high 3 cycles, RUN on ready cycle, count +3.
REQ-032 Branch: branch_taken 1 cycle -> cycle N both flushes, N+1 decode_flush only, N+2 none.
REQ-033 Branch under mem wait: branch_taken with dmem_req=1, ready=0 for 2 cycles -> stalls only, flushes on ready cycle.
REQ-034 Saturation: COUNT_WIDTH=4, 20 stall cycles -> stall_count_out stays 15.
REQ-035 Reset mid-FLUSH: rst_n low one cycle -> flushes 1, stalls 0, count 0, RUN after release.
